// File: rtl/pipe_phy_ctrl_responder.sv
// PHY-side responder for the PIPE MAC/PHY control handshake: reset-complete,
// power-state change, rate change and receiver detection, each acknowledged on phy_status.
module pipe_phy_ctrl_responder #(
    parameter int unsigned RESET_ACK_CYCLES   = 8,
    parameter int unsigned PD_CHANGE_CYCLES   = 8,
    parameter int unsigned RATE_CHANGE_CYCLES = 16,
    parameter int unsigned DETECT_CYCLES      = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] power_down,
    input  logic [3:0] rate,
    input  logic       tx_detect_rx,
    input  logic       tx_elec_idle,
    input  logic       rx_present,
    output logic       phy_status,
    output logic [2:0] rx_status,
    output logic       rx_elec_idle,
    output logic [3:0] cur_power_down,
    output logic [3:0] cur_rate
);

    localparam int unsigned MAX_AB = (RESET_ACK_CYCLES > PD_CHANGE_CYCLES) ?
                                     RESET_ACK_CYCLES : PD_CHANGE_CYCLES;
    localparam int unsigned MAX_CD = (RATE_CHANGE_CYCLES > DETECT_CYCLES) ?
                                     RATE_CHANGE_CYCLES : DETECT_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    // The counter only ever holds CYCLES-1, so clog2(max) bits are enough.
    localparam int unsigned CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [3:0] PD_P0   = 4'd0;
    localparam logic [3:0] PD_P0S  = 4'd1;
    localparam logic [3:0] PD_P1   = 4'd2;
    localparam logic [3:0] PD_P2   = 4'd3;
    localparam logic [3:0] RATE_MAX = 4'd4;
    localparam logic [2:0] RXS_DETECTED = 3'b011;

    typedef enum logic [2:0] {
        S_RESET_ACK,
        S_IDLE,
        S_PD_CHANGE,
        S_RATE_CHANGE,
        S_DETECT,
        S_ACK,
        S_DETECT_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       target_q, target_d;
    logic             det_flag_q, det_flag_d;
    logic             phy_status_d;
    logic [2:0]       rx_status_d;
    logic [3:0]       cur_power_down_d, cur_rate_d;

    logic pd_req, rate_req, det_req;

    assign pd_req   = (power_down <= PD_P2) && (power_down != cur_power_down);
    assign rate_req = (rate <= RATE_MAX) && (rate != cur_rate) &&
                      ((cur_power_down == PD_P0) || (cur_power_down == PD_P0S));
    assign det_req  = tx_detect_rx && tx_elec_idle && (cur_power_down == PD_P1);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        target_d         = target_q;
        det_flag_d       = det_flag_q;
        phy_status_d     = phy_status;
        rx_status_d      = rx_status;
        cur_power_down_d = cur_power_down;
        cur_rate_d       = cur_rate;

        unique case (state_q)
            S_RESET_ACK: begin
                if (cnt_q == '0) begin
                    phy_status_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IDLE: begin
                // Priority: power state, then rate (only in P0/P0s), then receiver detect (only in P1).
                if (pd_req) begin
                    target_d = power_down;
                    cnt_d    = CNT_W'(PD_CHANGE_CYCLES - 1);
                    state_d  = S_PD_CHANGE;
                end else if (rate_req) begin
                    target_d = rate;
                    cnt_d    = CNT_W'(RATE_CHANGE_CYCLES - 1);
                    state_d  = S_RATE_CHANGE;
                end else if (det_req) begin
                    cnt_d   = CNT_W'(DETECT_CYCLES - 1);
                    state_d = S_DETECT;
                end
            end
            S_PD_CHANGE: begin
                if (cnt_q == '0) begin
                    cur_power_down_d = target_q;
                    phy_status_d     = 1'b1;
                    state_d          = S_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RATE_CHANGE: begin
                if (cnt_q == '0) begin
                    cur_rate_d   = target_q;
                    phy_status_d = 1'b1;
                    state_d      = S_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DETECT: begin
                if (cnt_q == '0) begin
                    rx_status_d  = rx_present ? RXS_DETECTED : 3'b000;
                    phy_status_d = 1'b1;
                    det_flag_d   = 1'b1;
                    state_d      = S_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                phy_status_d = 1'b0;
                rx_status_d  = 3'b000;
                det_flag_d   = 1'b0;
                state_d      = det_flag_q ? S_DETECT_RELEASE : S_IDLE;
            end
            S_DETECT_RELEASE: begin
                // A held detect request must drop before another detect can be accepted.
                if (!tx_detect_rx) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_RESET_ACK;
            cnt_q          <= CNT_W'(RESET_ACK_CYCLES - 1);
            target_q       <= '0;
            det_flag_q     <= 1'b0;
            phy_status     <= 1'b1;
            rx_status      <= 3'b000;
            rx_elec_idle   <= 1'b1;
            cur_power_down <= PD_P1;
            cur_rate       <= 4'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            target_q       <= target_d;
            det_flag_q     <= det_flag_d;
            phy_status     <= phy_status_d;
            rx_status      <= rx_status_d;
            rx_elec_idle   <= !((cur_power_down == PD_P0) && rx_present);
            cur_power_down <= cur_power_down_d;
            cur_rate       <= cur_rate_d;
        end
    end

endmodule

// File: tb/tb_pipe_phy_ctrl_responder.sv
// Self-checking bench for pipe_phy_ctrl_responder: directed handshake scenarios then
// randomized traffic, all compared every cycle against an edge-scheduled reference model.
module tb_pipe_phy_ctrl_responder;

    localparam int RESET_ACK_CYCLES   = 8;
    localparam int PD_CHANGE_CYCLES   = 8;
    localparam int RATE_CHANGE_CYCLES = 16;
    localparam int DETECT_CYCLES      = 32;
    localparam int NEVER              = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] power_down;
    logic [3:0] rate;
    logic       tx_detect_rx;
    logic       tx_elec_idle;
    logic       rx_present;
    logic       phy_status;
    logic [2:0] rx_status;
    logic       rx_elec_idle;
    logic [3:0] cur_power_down;
    logic [3:0] cur_rate;

    always #5 clk = ~clk;

    pipe_phy_ctrl_responder #(
        .RESET_ACK_CYCLES  (RESET_ACK_CYCLES),
        .PD_CHANGE_CYCLES  (PD_CHANGE_CYCLES),
        .RATE_CHANGE_CYCLES(RATE_CHANGE_CYCLES),
        .DETECT_CYCLES     (DETECT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .power_down    (power_down),
        .rate          (rate),
        .tx_detect_rx  (tx_detect_rx),
        .tx_elec_idle  (tx_elec_idle),
        .rx_present    (rx_present),
        .phy_status    (phy_status),
        .rx_status     (rx_status),
        .rx_elec_idle  (rx_elec_idle),
        .cur_power_down(cur_power_down),
        .cur_rate      (cur_rate)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a timeline of edge numbers since reset release. An accepted
    // request schedules its acknowledge at accept+CYCLES; the next evaluation is two
    // edges after that, or, for detect, the edge after tx_detect_rx is seen low.
    typedef enum {K_PD, K_RATE, K_DET} kind_t;
    int         edge_n;
    int         free_edge;
    int         ack_edge;
    kind_t      kind;
    logic [3:0] tgt;
    bit         rel_wait;
    logic       m_phy;
    logic [2:0] m_rxs;
    logic       m_eidle;
    logic [3:0] m_pd;
    logic [3:0] m_rate;
    logic       prev_phy;
    int         pulses;

    task automatic model_reset();
        edge_n    = 0;
        free_edge = RESET_ACK_CYCLES + 1;
        ack_edge  = -1;
        kind      = K_PD;
        tgt       = 4'd0;
        rel_wait  = 1'b0;
        m_phy     = 1'b1;
        m_rxs     = 3'b000;
        m_eidle   = 1'b1;
        m_pd      = 4'd2;
        m_rate    = 4'd0;
        prev_phy  = 1'b1;
    endtask

    task automatic model_edge();
        edge_n++;
        m_eidle = !((m_pd == 4'd0) && rx_present);
        m_phy   = (edge_n < RESET_ACK_CYCLES);
        m_rxs   = 3'b000;
        if (edge_n == ack_edge) begin
            m_phy = 1'b1;
            case (kind)
                K_PD:   m_pd   = tgt;
                K_RATE: m_rate = tgt;
                K_DET:  m_rxs  = rx_present ? 3'b011 : 3'b000;
                default: ;
            endcase
        end
        if (rel_wait) begin
            if (edge_n >= ack_edge + 2 && !tx_detect_rx) begin
                rel_wait  = 1'b0;
                free_edge = edge_n + 1;
            end
        end else if (edge_n >= free_edge) begin
            if (power_down <= 4'd3 && power_down != m_pd) begin
                kind      = K_PD;
                tgt       = power_down;
                ack_edge  = edge_n + PD_CHANGE_CYCLES;
                free_edge = ack_edge + 2;
            end else if (rate <= 4'd4 && rate != m_rate && m_pd <= 4'd1) begin
                kind      = K_RATE;
                tgt       = rate;
                ack_edge  = edge_n + RATE_CHANGE_CYCLES;
                free_edge = ack_edge + 2;
            end else if (tx_detect_rx && tx_elec_idle && m_pd == 4'd2) begin
                kind      = K_DET;
                ack_edge  = edge_n + DETECT_CYCLES;
                rel_wait  = 1'b1;
                free_edge = NEVER;
            end
        end
    endtask

    task automatic compare_all();
        check("phy_status",     32'(phy_status),     32'(m_phy));
        check("rx_status",      32'(rx_status),      32'(m_rxs));
        check("rx_elec_idle",   32'(rx_elec_idle),   32'(m_eidle));
        check("cur_power_down", 32'(cur_power_down), 32'(m_pd));
        check("cur_rate",       32'(cur_rate),       32'(m_rate));
    endtask

    // One clock: model follows the edge, outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (phy_status && !prev_phy) pulses++;
        prev_phy = phy_status;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asserts reset between edges, checks the immediate reset values, releases it.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            compare_all();
        end
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        power_down   = 4'd2;
        rate         = 4'd0;
        tx_detect_rx = 1'b0;
        tx_elec_idle = 1'b1;
        rx_present   = 1'b1;
        pulses       = 0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        #2;
        reset = 1'b0;

        // Reset release: phy_status high for RESET_ACK_CYCLES edges, then low.
        run(12);
        check("reset_ack_pulses", 32'(pulses), 32'd0);

        // P1 -> P0, then rate change to Gen4 in P0.
        power_down = 4'd0;
        run(14);
        rate = 4'd3;
        pulses = 0;
        run(22);
        check("rate_p0_pulses", 32'(pulses), 32'd1);

        // In P2 a rate request stays pending until P0 is acknowledged.
        power_down = 4'd3;
        run(14);
        rate = 4'd1;
        pulses = 0;
        run(30);
        check("rate_p2_pending_pulses", 32'(pulses), 32'd0);
        power_down = 4'd0;
        pulses = 0;
        run(36);
        check("pd_then_rate_pulses", 32'(pulses), 32'd2);

        // Detect in P1 with receiver present, held request gives one pulse only.
        power_down = 4'd2;
        run(14);
        tx_detect_rx = 1'b1;
        pulses = 0;
        run(40);
        check("detect_pulses", 32'(pulses), 32'd1);
        pulses = 0;
        run(25);
        check("held_detect_pulses", 32'(pulses), 32'd0);
        tx_detect_rx = 1'b0;
        run(3);
        rx_present   = 1'b0;
        tx_detect_rx = 1'b1;
        run(40);
        tx_detect_rx = 1'b0;
        rx_present   = 1'b1;
        run(4);

        // Simultaneous power-down change and detect: power-down wins, detect dropped.
        power_down   = 4'd0;
        tx_detect_rx = 1'b1;
        pulses = 0;
        run(45);
        check("pd_vs_detect_pulses", 32'(pulses), 32'd1);
        tx_detect_rx = 1'b0;

        // Changing power_down mid-change still commits the first target.
        power_down = 4'd3;
        run(3);
        power_down = 4'd1;
        run(14);
        run(14);

        // Reset mid-rate-change discards the operation.
        rate = 4'd4;
        run(6);
        do_reset();
        pulses = 0;
        run(RESET_ACK_CYCLES + 1);
        check("reset_abort_pulses", 32'(pulses), 32'd0);
        run(40);

        // Randomized traffic.
        for (int c = 0; c < 5000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)        power_down   = 4'($urandom_range(0, 5));
            else if (r < 6)   rate         = 4'($urandom_range(0, 6));
            else if (r < 9)   tx_detect_rx = ~tx_detect_rx;
            else if (r == 9)  tx_elec_idle = ($urandom_range(0, 3) != 0);
            else if (r == 10) rx_present   = ~rx_present;
            if ($urandom_range(0, 1499) == 0) do_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_phy_ctrl_responder.md
# pipe_phy_ctrl_responder

PHY-side responder for the PIPE MAC/PHY control handshake. It consumes the MAC-driven control signals (power_down, rate, tx_detect_rx, tx_elec_idle) and produces the PHY-driven completion signals (phy_status, rx_status, rx_elec_idle), including the reset-complete, power-state-change, rate-change and receiver-detection handshakes. It serves as the far end of the MAC in PHY-less simulation and as the reference responder for the pipe agent.

## Interface
- RESET_ACK_CYCLES, 8: clock edges phy_status stays high after reset deasserts (≥1).
- PD_CHANGE_CYCLES, 8: clock edges from power-down request acceptance to acknowledge (≥1).
- RATE_CHANGE_CYCLES, 16: clock edges from rate request acceptance to acknowledge (≥1).
- DETECT_CYCLES, 32: clock edges from detect acceptance to result (≥1).

- clk  in  1  PIPE clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- power_down  in  4  requested power state: 0=P0, 1=P0s, 2=P1, 3=P2; values >3 ignored.
- rate  in  4  requested rate: 0..4 = Gen1..Gen5; values >4 ignored.
- tx_detect_rx  in  1  receiver-detect request (level).
- tx_elec_idle  in  1  MAC transmitter electrical idle.
- rx_present  in  1  bench-controlled far-end receiver presence.
- phy_status  out  1  PHY completion/acknowledge.
- rx_status  out  3  3'b011 = receiver detected, 3'b000 otherwise.
- rx_elec_idle  out  1  receiver electrical idle.
- cur_power_down  out  4  currently committed power state.
- cur_rate  out  4  currently committed rate.

## Operation
- States: RESET_ACK, IDLE, PD_CHANGE, RATE_CHANGE, DETECT, ACK, DETECT_RELEASE.
- Reset values: state=RESET_ACK, phy_status=1, rx_status=0, rx_elec_idle=1, cur_power_down=2 (P1), cur_rate=0, counter=RESET_ACK_CYCLES-1.
- RESET_ACK: counter decrements per edge; at 0 → IDLE with phy_status=0.
- IDLE evaluates requests each edge, in priority order:
  1. power_down ≤3 and ≠ cur_power_down → capture target, load PD_CHANGE_CYCLES-1, → PD_CHANGE.
  2. rate ≤4, ≠ cur_rate, and cur_power_down ∈ {P0,P0s} → capture target, load RATE_CHANGE_CYCLES-1, → RATE_CHANGE. In P1/P2 a rate request stays pending; no acknowledge.
  3. tx_detect_rx=1, tx_elec_idle=1, cur_power_down=P1 → load DETECT_CYCLES-1, → DETECT.
- PD_CHANGE / RATE_CHANGE: decrement; on the edge the counter is 0, commit the captured target to cur_power_down/cur_rate, set phy_status=1, → ACK.
- DETECT: decrement; on the edge the counter is 0, set rx_status = rx_present ? 3'b011 : 3'b000 (rx_present sampled at that edge), set phy_status=1, → ACK (detect flag set).
- ACK: next edge phy_status=0, rx_status=0; → DETECT_RELEASE if the detect flag is set, else → IDLE.
- DETECT_RELEASE: hold until tx_detect_rx=0, then → IDLE. Prevents a repeat detect on a held request.
- Input changes while busy are ignored; the captured target completes. New values are re-evaluated in IDLE, so one request is accepted per acknowledge.
- rx_elec_idle is registered each edge: 0 iff cur_power_down=P0 and rx_present=1, else 1.
- Reset asserted in any state: all outputs take reset values immediately. The in-flight operation is discarded with no acknowledge.

## Timing
- Request stable before edge N (state IDLE): phy_status rises after edge N+CYCLES, is high for exactly one cycle, and falls after edge N+CYCLES+1. cur_* updates at the same edge phy_status rises.
- Reset deassert, then first edge E1: phy_status falls after edge E1+RESET_ACK_CYCLES-1. The earliest request acceptance is the following edge.
- rx_status is nonzero only in the same cycle phy_status is high for a detect.
- rx_elec_idle lags cur_power_down/rx_present by one edge.
- Back-to-back requests: minimum spacing between acknowledges is CYCLES+2 edges (ACK plus one IDLE evaluation).

## Test plan
- Reset release: phy_status=1 during reset, remains 1 for 8 edges after deassert, then 0; cur_power_down=2, cur_rate=0, rx_elec_idle=1.
- P1→P0: power_down=0 at edge N → phy_status high exactly during cycle after N+8, cur_power_down=0; rx_elec_idle=0 one edge later with rx_present=1.
- Rate change in P0 (rate=3) → single phy_status pulse after N+16, cur_rate=3. Same request in P2 → no pulse, cur_rate unchanged until power_down=0 is acknowledged, then rate accepted.
- Detect in P1, tx_elec_idle=1, rx_present=1 → after N+32 phy_status=1 with rx_status=3'b011 for one cycle. With rx_present=0 → rx_status=3'b000. tx_detect_rx held high yields no second pulse until it drops and re-asserts.
- Simultaneous power_down change and tx_detect_rx → power_down is serviced first, and detect is not taken once the state leaves P1. Changing power_down mid-PD_CHANGE still commits the first target.
- Reset asserted mid-RATE_CHANGE → immediate reset values, no acknowledge pulse, RESET_ACK sequence restarts.
